digit_index_search: RTL and testbench

- Reverse lookup for the fixed 16-entry hex digit sequence used by the display path, which maps a 4-bit index to a 4-bit digit.
- Given a 4-bit digit (key), the block scans all 16 indices, one per clock.
- It reports whether the digit occurs, the first and last index where it occurs, and how many times it occurs.
- Sits beside the display sequencer so switch or button logic can locate digits in the displayed sequence.

---
 rtl/digit_index_search.sv | 125 ++++++++++++
 tb/tb_digit_index_search.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/digit_index_search.sv
// Reverse lookup over the fixed 16-entry display digit sequence: scans one index
// per clock and reports presence, first/last matching index and match count.
module digit_index_search (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] key,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic [3:0] first_idx,
    output logic [3:0] last_idx,
    output logic [4:0] match_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] idx;
    logic [3:0] key_q;
    logic [4:0] cnt_acc;
    logic [3:0] first_acc;
    logic [3:0] last_acc;

    logic       match;
    logic [4:0] cnt_nxt;
    logic [3:0] first_nxt;
    logic [3:0] last_nxt;

    // Same sequence the display path walks through, index -> digit.
    function automatic logic [3:0] digit_at(input logic [3:0] i);
        case (i)
            4'd0:    digit_at = 4'hA;
            4'd1:    digit_at = 4'hA;
            4'd2:    digit_at = 4'hC;
            4'd3:    digit_at = 4'hB;
            4'd4:    digit_at = 4'hF;
            4'd5:    digit_at = 4'hF;
            4'd6:    digit_at = 4'hE;
            4'd7:    digit_at = 4'hE;
            4'd8:    digit_at = 4'hA;
            4'd9:    digit_at = 4'h1;
            4'd10:   digit_at = 4'h5;
            4'd11:   digit_at = 4'hA;
            4'd12:   digit_at = 4'h9;
            4'd13:   digit_at = 4'hB;
            4'd14:   digit_at = 4'hB;
            default: digit_at = 4'hD;
        endcase
    endfunction

    // Accumulator values after the current compare; the final scan edge loads
    // the outputs from these so the idx-15 compare is included.
    always_comb begin
        match     = (digit_at(idx) == key_q);
        cnt_nxt   = cnt_acc;
        first_nxt = first_acc;
        last_nxt  = last_acc;
        if (match) begin
            cnt_nxt  = cnt_acc + 5'd1;
            last_nxt = idx;
            if (cnt_acc == 5'd0) begin
                first_nxt = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 4'd0;
            key_q     <= 4'd0;
            cnt_acc   <= 5'd0;
            first_acc <= 4'd0;
            last_acc  <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            first_idx <= 4'd0;
            last_idx  <= 4'd0;
            match_cnt <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        key_q     <= key;
                        idx       <= 4'd0;
                        cnt_acc   <= 5'd0;
                        first_acc <= 4'd0;
                        last_acc  <= 4'd0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end else begin
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    cnt_acc   <= cnt_nxt;
                    first_acc <= first_nxt;
                    last_acc  <= last_nxt;
                    idx       <= idx + 4'd1;
                    if (idx == 4'd15) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        found     <= (cnt_nxt != 5'd0);
                        first_idx <= first_nxt;
                        last_idx  <= last_nxt;
                        match_cnt <= cnt_nxt;
                        state     <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_index_search.sv
// Scoreboard bench for digit_index_search: directed searches push expected
// results, a monitor pops and compares on every done pulse.
module tb_digit_index_search;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] key;
    logic       busy;
    logic       done;
    logic       found;
    logic [3:0] first_idx;
    logic [3:0] last_idx;
    logic [4:0] match_cnt;

    typedef struct {
        logic       fnd;
        logic [3:0] first;
        logic [3:0] last;
        logic [4:0] cnt;
    } exp_t;

    exp_t expQ[$];
    int   checks    = 0;
    int   errors    = 0;
    int   doneCount = 0;

    digit_index_search dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key       (key),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .match_cnt (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            doneCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("found", int'(found), int'(e.fnd));
                checkOutput("first_idx", int'(first_idx), int'(e.first));
                checkOutput("last_idx", int'(last_idx), int'(e.last));
                checkOutput("match_cnt", int'(match_cnt), int'(e.cnt));
            end
        end
    end

    // Issues a one-cycle start; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [3:0] k, input bit expectDone,
                                 input logic fnd, input logic [3:0] f,
                                 input logic [3:0] l, input logic [4:0] c);
        exp_t e;
        if (expectDone) begin
            e.fnd = fnd; e.first = f; e.last = l; e.cnt = c;
            expQ.push_back(e);
        end
        key   = k;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Waits (bounded) for done; reports cycles taken and busy cycles seen.
    task automatic waitDone(input int budget, output int n, output int busyCnt);
        bit got = 0;
        n = 0;
        busyCnt = 0;
        while (n < budget && !got) begin
            if (busy) busyCnt++;
            @(posedge clk);
            #1;
            n++;
            if (done) got = 1;
        end
        if (!got) checkOutput("done_timeout", 0, 1);
    endtask

    initial begin
        int n, bc, dc;
        rst_n = 1'b0;
        start = 1'b0;
        key   = 4'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_found", int'(found), 0);
        checkOutput("reset_first", int'(first_idx), 0);
        checkOutput("reset_last", int'(last_idx), 0);
        checkOutput("reset_cnt", int'(match_cnt), 0);
        repeat (40) @(posedge clk);
        #1 checkOutput("idle_no_done", doneCount, 0);

        // key A: matches at 0,1,8,11
        applyStimulus(4'hA, 1, 1'b1, 4'd0, 4'd11, 5'd4);
        waitDone(40, n, bc);
        checkOutput("latency_A", n, 16);
        checkOutput("busy_cycles_A", bc, 16);
        checkOutput("busy_in_done", int'(busy), 0);

        // Back-to-back: B then D started in B's DONE cycle
        @(posedge clk);
        #1;
        applyStimulus(4'hB, 1, 1'b1, 4'd3, 4'd14, 5'd3);
        waitDone(40, n, bc);
        checkOutput("latency_B", n, 16);
        applyStimulus(4'hD, 1, 1'b1, 4'd15, 4'd15, 5'd1);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("hold_busy", int'(busy), 1);
        checkOutput("hold_found", int'(found), 1);
        checkOutput("hold_first", int'(first_idx), 3);
        checkOutput("hold_last", int'(last_idx), 14);
        checkOutput("hold_cnt", int'(match_cnt), 3);
        waitDone(40, n, bc);
        checkOutput("latency_D_rest", n, 8);

        // Absent digits
        @(posedge clk);
        #1;
        applyStimulus(4'h0, 1, 1'b0, 4'd0, 4'd0, 5'd0);
        waitDone(40, n, bc);
        @(posedge clk);
        #1;
        applyStimulus(4'h7, 1, 1'b0, 4'd0, 4'd0, 5'd0);
        waitDone(40, n, bc);

        // key F with an ignored start/key change mid-scan
        @(posedge clk);
        #1;
        dc = doneCount;
        applyStimulus(4'hF, 1, 1'b1, 4'd4, 4'd5, 5'd2);
        repeat (5) @(posedge clk);
        #1 key = 4'hA;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(40, n, bc);
        checkOutput("latency_F_rest", n, 10);
        repeat (25) @(posedge clk);
        #1;
        checkOutput("single_done_F", doneCount - dc, 1);
        checkOutput("idle_after_F", int'(busy), 0);

        // key E aborted by reset mid-scan
        applyStimulus(4'hE, 0, 1'b0, 4'd0, 4'd0, 5'd0);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_found", int'(found), 0);
        checkOutput("abort_first", int'(first_idx), 0);
        checkOutput("abort_last", int'(last_idx), 0);
        checkOutput("abort_cnt", int'(match_cnt), 0);
        dc = doneCount;
        repeat (20) @(posedge clk);
        #1 checkOutput("abort_no_done", doneCount, dc);

        applyStimulus(4'hE, 1, 1'b1, 4'd6, 4'd7, 5'd2);
        waitDone(40, n, bc);
        checkOutput("latency_E", n, 16);
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", int'(done), 0);
        checkOutput("queue_empty", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
